// File: rtl/led_seq.sv
// LED pattern sequencer: stores up to DEPTH timed LED steps and plays them back.
// Define LED_SEQ_LOOP_EN to repeat the pattern continuously instead of a one-shot run ending in a done pulse.
module led_seq #(
  parameter int unsigned TICK_DIV = 5_000_000,
  parameter int unsigned DEPTH    = 8,
  parameter logic [1:0]  IDLE_LED = 2'b10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [1:0] led_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned PW = 26;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {
    S_IDLE,
    S_PLAY
  } state_e;

  state_e        state_q;
  logic [CW-1:0] count_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic [PW-1:0] presc_q;
  logic [5:0]    tick_q;
  logic [1:0]    led_q;
  logic          done_q;
  logic [7:0]    mem_q [DEPTH];

  logic write_en;
  logic tick;
  logic step_end;
  logic last_step;

  assign cmd_ready = (state_q == S_IDLE) && (count_q < DEPTH_C);
  assign write_en  = cmd_valid && cmd_ready && !clear;
  assign tick      = (presc_q == PRESC_MAX);
  assign step_end  = tick && (tick_q == mem_q[idx_q][7:2]);
  assign last_step = (({1'b0, idx_q} + CW'(1)) == count_q);
  assign idx_d     = idx_q + IW'(1);

  assign led_out = led_q;
  assign busy    = (state_q == S_PLAY);
  assign done    = done_q;

  // NOTE: step storage is deliberately not reset; count_q = 0 makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (write_en) mem_q[count_q[IW-1:0]] <= cmd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      presc_q <= '0;
      tick_q  <= '0;
      led_q   <= IDLE_LED;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Clear beats both a same-cycle write and a same-cycle start.
          if (clear) begin
            count_q <= '0;
          end else begin
            if (write_en) count_q <= count_q + CW'(1);
            if (start && !stop && (count_q != '0)) begin
              state_q <= S_PLAY;
              idx_q   <= '0;
              presc_q <= '0;
              tick_q  <= '0;
              led_q   <= mem_q[0][1:0];
            end
          end
        end
        S_PLAY: begin
          if (stop) begin
            state_q <= S_IDLE;
            led_q   <= IDLE_LED;
          end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (step_end) begin
              tick_q <= '0;
              if (!last_step) begin
                idx_q <= idx_d;
                led_q <= mem_q[idx_d][1:0];
              end else begin
`ifdef LED_SEQ_LOOP_EN
                idx_q <= '0;
                led_q <= mem_q[0][1:0];
`else
                state_q <= S_IDLE;
                led_q   <= IDLE_LED;
                done_q  <= 1'b1;
`endif
              end
            end else if (tick) begin
              tick_q <= tick_q + 6'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_seq.sv
// Self-checking bench for led_seq (TICK_DIV = 4, DEPTH = 8); the model is a queue of
// stored steps from which the expected LED timeline is derived arithmetically.
module tb_led_seq;

  localparam int TICK  = 4;
  localparam int DEPTH = 8;
  localparam logic [1:0] IDLE_LED = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       start;
  logic       stop;
  logic       clear;
  logic [1:0] led_out;
  logic       busy;
  logic       done;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] mdl[$];

  led_seq #(
    .TICK_DIV(TICK),
    .DEPTH   (DEPTH),
    .IDLE_LED(IDLE_LED)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data (cmd_data),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .led_out  (led_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int dur(input logic [7:0] s);
    return (int'(s[7:2]) + 1) * TICK;
  endfunction

  function automatic int total_cycles();
    int t = 0;
    foreach (mdl[i]) t += dur(mdl[i]);
    return t;
  endfunction

  function automatic logic [7:0] rand_step();
    logic [5:0] d;
    logic [1:0] l;
    d = 6'($urandom_range(0, 3));
    l = 2'($urandom_range(0, 3));
    return {d, l};
  endfunction

  task automatic wr(input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    check("wr_ready", {7'd0, cmd_ready}, {7'd0, mdl.size() < DEPTH});
    if (mdl.size() < DEPTH) mdl.push_back(d);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic clr_with_valid();
    clear     = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = rand_step();
    step();
    clear     = 1'b0;
    cmd_valid = 1'b0;
    mdl.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {7'd0, busy}, 8'd0);
    check({tag, "_led"}, {6'd0, led_out}, {6'd0, IDLE_LED});
    check({tag, "_done"}, {7'd0, done}, 8'd0);
  endtask

  // Start playback and follow the expected timeline cycle by cycle; clear is pulsed at
  // cycle clear_k, stop (together with start) at cycle stop_k; -1 disables either.
  task automatic play(input string tag, input int clear_k, input int stop_k);
    int tot;
    int acc;
    int si;
    tot   = total_cycles();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < tot; k++) begin
      acc = 0;
      si  = 0;
      while (acc + dur(mdl[si]) <= k) begin
        acc += dur(mdl[si]);
        si++;
      end
      check({tag, "_led"}, {6'd0, led_out}, {6'd0, mdl[si][1:0]});
      check({tag, "_busy"}, {7'd0, busy}, 8'd1);
      check({tag, "_done"}, {7'd0, done}, 8'd0);
      if (k == stop_k) begin
        stop  = 1'b1;
        start = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        check_idle({tag, "_stopped"});
        return;
      end
      clear = (k == clear_k);
      step();
      clear = 1'b0;
    end
`ifdef LED_SEQ_LOOP_EN
    check({tag, "_wrap_led"}, {6'd0, led_out}, {6'd0, mdl[0][1:0]});
    check({tag, "_wrap_busy"}, {7'd0, busy}, 8'd1);
    check({tag, "_wrap_done"}, {7'd0, done}, 8'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle({tag, "_end"});
`else
    check({tag, "_end_led"}, {6'd0, led_out}, {6'd0, IDLE_LED});
    check({tag, "_end_busy"}, {7'd0, busy}, 8'd0);
    check({tag, "_end_done"}, {7'd0, done}, 8'd1);
    step();
    check_idle({tag, "_post"});
`endif
  endtask

  initial begin
    int tot;
    int n;
    int sk;
    int ck;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 8'd0;
    start     = 1'b0;
    stop      = 1'b0;
    clear     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    check("ready_after_reset", {7'd0, cmd_ready}, 8'd1);

    // Fill the memory back-to-back; the ninth write must be refused.
    cmd_valid = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      cmd_data = rand_step();
      check("fill_ready", {7'd0, cmd_ready}, {7'd0, mdl.size() < DEPTH});
      if (mdl.size() < DEPTH) mdl.push_back(cmd_data);
      step();
    end
    cmd_valid = 1'b0;
    check("full_ready", {7'd0, cmd_ready}, 8'd0);
    play("fill8", -1, -1);

    // Empty memory: start must be ignored.
    clr_with_valid();
    check("clr_ready", {7'd0, cmd_ready}, 8'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_idle("start_empty");
      step();
    end

    // Two-step directed pattern, then replay without reloading.
    wr(8'h01);
    wr(8'h0B);
    play("two_step", -1, -1);
    play("two_step_again", -1, -1);

    // Stop on the exact edge that ends the middle of three steps, then replay.
    clr_with_valid();
    for (int i = 0; i < 3; i++) wr(rand_step());
    play("stop_edge", -1, dur(mdl[0]) + dur(mdl[1]) - 1);
    play("after_stop", -1, -1);

    // Clear with a write in IDLE (count 3) discards everything; clear during PLAY is ignored.
    clr_with_valid();
    for (int i = 0; i < 3; i++) wr(rand_step());
    clr_with_valid();
    wr(8'h06);
    wr(8'h03);
    play("clr_in_play", 3, -1);

    // Asynchronous reset between clock edges in the middle of playback.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    #3;
    rst_n = 1'b1;
    mdl.delete();
    step();
    check("rst_release_ready", {7'd0, cmd_ready}, 8'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check_idle("start_after_rst");
    wr(rand_step());
    play("after_rst_write", -1, -1);

    // Randomized patterns with occasional clear and stop during playback.
    for (int r = 0; r < 8; r++) begin
      clr_with_valid();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) wr(rand_step());
      tot = total_cycles();
      sk  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, tot - 1)) : -1;
      ck  = int'($urandom_range(0, tot - 1));
      play("rand", ck, sk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
